// File: rtl/encoder_pkg.sv
// Shared definitions for the one-hot encoder: default widths, the encode
// result record and the combinational one-hot-to-binary function.
package encoder_pkg;

    localparam int ENC_W_IN     = 8;
    localparam int ENC_CODE_W   = 3;

    // The encode function works on a fixed wide word; callers zero-extend
    // their input and keep only the low code bits they need.
    localparam int ENC_MAX_W      = 256;
    localparam int ENC_MAX_CODE_W = 8;

    typedef struct packed {
        logic [ENC_MAX_CODE_W-1:0] code;
        logic                      zero;
        logic                      multi;
    } enc_res_t;

    // Returns {code, zero, multi}. With several bits set, lsb_first picks the
    // lowest set index, otherwise the highest one.
    function automatic enc_res_t onehot_to_bin(input logic [ENC_MAX_W-1:0] word,
                                               input logic                 lsb_first);
        enc_res_t res;
        logic     seen;
        res.code  = {ENC_MAX_CODE_W{1'b0}};
        res.zero  = 1'b0;
        res.multi = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < ENC_MAX_W; i++) begin
            if (word[i]) begin
                if (seen) begin
                    res.multi = 1'b1;
                end else begin
                    res.multi = res.multi;
                end
                if (!seen || !lsb_first) begin
                    res.code = ENC_MAX_CODE_W'(i);
                end else begin
                    res.code = res.code;
                end
                seen = 1'b1;
            end else begin
                seen = seen;
            end
        end
        res.zero = ~seen;
        return res;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: an output register plus one skid
// entry. in_ready comes straight from a flop, so it never depends
// combinationally on out_ready.
module skid_buffer #(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic          skid_valid_r;
    logic [DW-1:0] skid_data_r;

    logic          out_valid_n_s;
    logic [DW-1:0] out_data_n_s;
    logic          skid_valid_n_s;
    logic [DW-1:0] skid_data_n_s;

    logic          accept_s;
    logic          load_out_s;

    assign in_ready   = ~skid_valid_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign accept_s   = in_valid & ~skid_valid_r;
    assign load_out_s = ~out_valid_r | out_ready;

    // Next-state: refill the output stage from skid first (FIFO order), park
    // an accepted word in skid while the output is held.
    always_comb begin
        out_valid_n_s  = out_valid_r;
        out_data_n_s   = out_data_r;
        skid_valid_n_s = skid_valid_r;
        skid_data_n_s  = skid_data_r;
        if (load_out_s) begin
            if (skid_valid_r) begin
                out_valid_n_s  = 1'b1;
                out_data_n_s   = skid_data_r;
                skid_valid_n_s = 1'b0;
            end else if (accept_s) begin
                out_valid_n_s  = 1'b1;
                out_data_n_s   = in_data;
            end else begin
                out_valid_n_s  = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_n_s = 1'b1;
                skid_data_n_s  = in_data;
            end else begin
                skid_valid_n_s = skid_valid_r;
            end
        end
    end

    // Slice registers; reset drops every held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {DW{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DW{1'b0}};
        end else begin
            out_valid_r  <= out_valid_n_s;
            out_data_r   <= out_data_n_s;
            skid_valid_r <= skid_valid_n_s;
            skid_data_r  <= skid_data_n_s;
        end
    end

endmodule

// File: rtl/onehot_encoder.sv
// Registered one-hot to binary encoder with valid/ready on both sides,
// zero/multi-hot flags and a saturating error counter counted at accept.
module onehot_encoder
    import encoder_pkg::*;
#(
    parameter int W_IN         = ENC_W_IN,
    parameter int CODE_W       = ENC_CODE_W,
    parameter int ERR_CNT_W    = 8,
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_IN-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CODE_W-1:0]    out_code,
    output logic                 out_zero,
    output logic                 out_multi,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int DW = CODE_W + 2;

    enc_res_t               enc_s;
    logic [CODE_W-1:0]      code_s;
    logic [DW-1:0]          slice_in_s;
    logic [DW-1:0]          slice_out_s;
    logic                   accept_s;
    logic                   is_err_s;
    logic                   unused_code_hi_s;
    logic [ERR_CNT_W-1:0]   err_base_s;
    logic [ERR_CNT_W-1:0]   err_cnt_n_s;
    logic [ERR_CNT_W-1:0]   err_cnt_r;

    assign enc_s            = onehot_to_bin(ENC_MAX_W'(in_data), PRIORITY_LSB);
    assign code_s           = enc_s.code[CODE_W-1:0];
    // Upper code bits are always zero because the word is zero-extended.
    assign unused_code_hi_s = ^enc_s.code[ENC_MAX_CODE_W-1:CODE_W];
    assign slice_in_s       = {code_s, enc_s.zero, enc_s.multi};
    assign accept_s         = in_valid & in_ready;
    assign is_err_s         = enc_s.zero | enc_s.multi;

    skid_buffer #(
        .DW (DW)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (slice_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (slice_out_s)
    );

    assign {out_code, out_zero, out_multi} = slice_out_s;
    assign err_cnt = err_cnt_r;

    // Error counter next value: clear acts on the old value, then an
    // erroneous accept adds one unless already saturated.
    always_comb begin
        err_base_s  = err_cnt_r;
        err_cnt_n_s = err_cnt_r;
        if (err_clr) begin
            err_base_s = {ERR_CNT_W{1'b0}};
        end else begin
            err_base_s = err_cnt_r;
        end
        if (accept_s && is_err_s && (err_base_s != {ERR_CNT_W{1'b1}})) begin
            err_cnt_n_s = err_base_s + ERR_CNT_W'(1'b1);
        end else begin
            err_cnt_n_s = err_base_s;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else begin
            err_cnt_r <= err_cnt_n_s;
        end
    end

endmodule

// File: tb/tb_onehot_encoder.sv
// Self-checking bench for onehot_encoder: two instances (LSB priority with an
// 8-bit counter, MSB priority with a 2-bit counter) share one stimulus and are
// checked every cycle against a queue-based reference model.
module tb_onehot_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;

    logic       in_ready_a, out_valid_a, out_zero_a, out_multi_a;
    logic [2:0] out_code_a;
    logic [7:0] err_cnt_a;
    logic       in_ready_b, out_valid_b, out_zero_b, out_multi_b;
    logic [2:0] out_code_b;
    logic [1:0] err_cnt_b;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];
    int err_a = 0;
    int err_b = 0;
    int accepted = 0;
    int sat_exp[5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    onehot_encoder #(.W_IN(8), .CODE_W(3), .ERR_CNT_W(8), .PRIORITY_LSB(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_code(out_code_a),
        .out_zero(out_zero_a), .out_multi(out_multi_a), .err_clr(err_clr), .err_cnt(err_cnt_a)
    );

    onehot_encoder #(.W_IN(8), .CODE_W(3), .ERR_CNT_W(2), .PRIORITY_LSB(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_code(out_code_b),
        .out_zero(out_zero_b), .out_multi(out_multi_b), .err_clr(err_clr), .err_cnt(err_cnt_b)
    );

    // Reference encode from arithmetic: result packed as code*4 + zero*2 + multi.
    function automatic int ref_enc(int w, bit lsb);
        int n, low, high, code;
        if (w == 0) return 2;
        n    = $countones(w);
        low  = $clog2(w & -w);
        high = $clog2(w + 1) - 1;
        code = (n == 1 || lsb) ? low : high;
        return code * 4 + ((n > 1) ? 1 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the model's current state.
    task automatic check_state();
        chk("in_ready_a", in_ready_a, qa.size() < 2);
        chk("in_ready_b", in_ready_b, qb.size() < 2);
        chk("out_valid_a", out_valid_a, qa.size() > 0);
        chk("out_valid_b", out_valid_b, qb.size() > 0);
        if (qa.size() > 0) begin
            chk("code_a", out_code_a, qa[0] >> 2);
            chk("zero_a", out_zero_a, (qa[0] >> 1) & 1);
            chk("multi_a", out_multi_a, qa[0] & 1);
        end
        if (qb.size() > 0) begin
            chk("code_b", out_code_b, qb[0] >> 2);
            chk("zero_b", out_zero_b, (qb[0] >> 1) & 1);
            chk("multi_b", out_multi_b, qb[0] & 1);
        end
        chk("err_cnt_a", err_cnt_a, err_a);
        chk("err_cnt_b", err_cnt_b, err_b);
    endtask

    // One clock: check state, drive inputs, advance the model, step the clock.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
        bit acc, xfer;
        int ea, eb;
        check_state();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        err_clr   = c;
        acc  = v && (qa.size() < 2);
        xfer = (qa.size() > 0) && r;
        ea   = ref_enc(int'(d), 1'b1);
        eb   = ref_enc(int'(d), 1'b0);
        if (xfer) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        if (c) begin
            err_a = 0;
            err_b = 0;
        end
        if (acc) begin
            qa.push_back(ea);
            qb.push_back(eb);
            accepted++;
            if ((ea & 3) != 0 && err_a < 255) err_a++;
            if ((eb & 3) != 0 && err_b < 3) err_b++;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for one cycle with garbage on the input that must be ignored.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        err_a = 0;
        err_b = 0;
    endtask

    initial begin
        bit         v, r, c;
        logic [7:0] d;
        int         ncyc;

        // Reset values
        do_reset();
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_in_ready", in_ready_a, 1'b1);
        chk("rst_out_code", out_code_a, 3'd0);
        chk("rst_out_zero", out_zero_a, 1'b0);
        chk("rst_out_multi", out_multi_a, 1'b0);
        chk("rst_err_cnt", err_cnt_a, 8'd0);

        // One-hot sweep at full throughput
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(1 << i), 1'b1, 1'b0);
        chk("sweep_last_code", out_code_a, 3'd7);
        chk("sweep_err", err_cnt_a, 8'd0);

        // Zero and multi-hot words
        cyc(1'b1, 8'h00, 1'b1, 1'b0);
        chk("zero_code", out_code_a, 3'd0);
        chk("zero_flag", out_zero_a, 1'b1);
        cyc(1'b1, 8'h24, 1'b1, 1'b0);
        chk("multi_code_lsb", out_code_a, 3'd2);
        chk("multi_code_msb", out_code_b, 3'd5);
        chk("multi_flag", out_multi_a, 1'b1);
        chk("err_after_two", err_cnt_a, 8'd2);

        // Backpressure: three cycles of out_ready=0
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        chk("bp_in_ready_low", in_ready_a, 1'b0);
        cyc(1'b1, 8'h40, 1'b0, 1'b0);
        chk("bp_hold_code", out_code_a, 3'd1);
        cyc(1'b1, 8'h40, 1'b1, 1'b0);
        chk("bp_second_code", out_code_a, 3'd3);
        cyc(1'b1, 8'h40, 1'b1, 1'b0);
        chk("bp_third_code", out_code_a, 3'd6);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_drained", out_valid_a, 1'b0);

        // Saturation on the 2-bit counter, then clear interactions
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h00, 1'b1, 1'b0);
            chk("sat_step", err_cnt_b, sat_exp[i]);
        end
        cyc(1'b1, 8'h00, 1'b1, 1'b1);
        chk("clr_with_err_b", err_cnt_b, 2'd1);
        chk("clr_with_err_a", err_cnt_a, 8'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr_alone", err_cnt_a, 8'd0);

        // Reset with output and skid both full
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 1'b0, 1'b0);
        chk("full_in_ready", in_ready_a, 1'b0);
        chk("full_err", err_cnt_a, 8'd2);
        do_reset();
        chk("rst_full_out_valid", out_valid_a, 1'b0);
        chk("rst_full_in_ready", in_ready_a, 1'b1);
        chk("rst_full_err", err_cnt_a, 8'd0);
        cyc(1'b1, 8'h10, 1'b1, 1'b0);
        chk("post_rst_valid", out_valid_a, 1'b1);
        chk("post_rst_code", out_code_a, 3'd4);

        // Random traffic against the model
        accepted = 0;
        ncyc     = 0;
        while (accepted < 10000 && ncyc < 40000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) d = 8'(1 << $urandom_range(0, 7));
            else d = 8'($urandom_range(0, 255));
            cyc(v, d, r, c);
            ncyc++;
        end
        chk("rand_budget", accepted >= 10000, 1'b1);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_state();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
